// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: two-requester round-robin APB master with a wait-state
// timeout. It shares one APB port between requester 0 and requester 1, drives
// the SETUP/ACCESS handshake and returns completion, error and read data to
// whichever requester owns the current transfer.
module apb_master_arbiter #(
  parameter int BUS_WIDTH  = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [1:0]              req_i,
  input  logic [1:0]              write_i,
  input  logic [ADDR_WIDTH-1:0]   addr0_i,
  input  logic [ADDR_WIDTH-1:0]   addr1_i,
  input  logic [BUS_WIDTH-1:0]    wdata0_i,
  input  logic [BUS_WIDTH-1:0]    wdata1_i,
  input  logic [BUS_WIDTH/8-1:0]  strb0_i,
  input  logic [BUS_WIDTH/8-1:0]  strb1_i,
  output logic [1:0]              gnt_o,
  output logic [1:0]              done_o,
  output logic                    err_o,
  output logic [BUS_WIDTH-1:0]    rdata_o,
  output logic                    psel_o,
  output logic                    penable_o,
  output logic                    pwrite_o,
  output logic [ADDR_WIDTH-1:0]   paddr_o,
  output logic [BUS_WIDTH-1:0]    pwdata_o,
  output logic [BUS_WIDTH/8-1:0]  pstrb_o,
  input  logic                    pready_i,
  input  logic                    pslverr_i,
  input  logic [BUS_WIDTH-1:0]    prdata_i,
  input  logic                    busy_i
);

  localparam int STRB_WIDTH = BUS_WIDTH / 8;
  localparam int CNT_WIDTH  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t                 state_q, state_d;
  logic                   last_gnt_q, last_gnt_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [1:0]             gnt_q, gnt_d;
  logic [1:0]             done_q, done_d;
  logic                   err_q, err_d;
  logic [BUS_WIDTH-1:0]   rdata_q, rdata_d;
  logic                   psel_q, psel_d;
  logic                   penable_q, penable_d;
  logic                   pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0]  paddr_q, paddr_d;
  logic [BUS_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic [STRB_WIDTH-1:0]  pstrb_q, pstrb_d;
  logic                   winner;

  // Next-state and next-output logic; every register holds unless a state says otherwise.
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    cnt_d      = cnt_q;
    gnt_d      = gnt_q;
    done_d     = done_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    psel_d     = psel_q;
    penable_d  = penable_q;
    pwrite_d   = pwrite_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    pstrb_d    = pstrb_q;
    winner     = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_i != 2'b00 && !busy_i) begin
          // On a tie the requester that did not win last time goes next.
          if (req_i == 2'b11) winner = ~last_gnt_q;
          else                winner = req_i[1];
          state_d    = SETUP;
          last_gnt_d = winner;
          gnt_d      = winner ? 2'b10 : 2'b01;
          psel_d     = 1'b1;
          penable_d  = 1'b0;
          pwrite_d   = write_i[winner];
          paddr_d    = winner ? addr1_i : addr0_i;
          pwdata_d   = winner ? wdata1_i : wdata0_i;
          if (write_i[winner]) pstrb_d = winner ? strb1_i : strb0_i;
          else                 pstrb_d = '0;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      ACCESS: begin
        if (pready_i) begin
          state_d   = DONE;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          err_d     = pslverr_i;
          rdata_d   = pwrite_q ? '0 : prdata_i;
          done_d    = gnt_q;
        end else if (cnt_q == CNT_WIDTH'(TIMEOUT - 1)) begin
          // This is the last permitted wait cycle: abort the transfer.
          state_d   = DONE;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          err_d     = 1'b1;
          rdata_d   = '0;
          done_d    = gnt_q;
        end else if (cnt_q != CNT_WIDTH'(TIMEOUT)) begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
        done_d  = 2'b00;
        err_d   = 1'b0;
        rdata_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, cleared immediately on reset so no stale done leaks out.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      cnt_q      <= '0;
      gnt_q      <= 2'b00;
      done_q     <= 2'b00;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      psel_q     <= 1'b0;
      penable_q  <= 1'b0;
      pwrite_q   <= 1'b0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      pstrb_q    <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      psel_q     <= psel_d;
      penable_q  <= penable_d;
      pwrite_q   <= pwrite_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
      pstrb_q    <= pstrb_d;
    end
  end

  assign gnt_o     = gnt_q;
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign rdata_o   = rdata_q;
  assign psel_o    = psel_q;
  assign penable_o = penable_q;
  assign pwrite_o  = pwrite_q;
  assign paddr_o   = paddr_q;
  assign pwdata_o  = pwdata_q;
  assign pstrb_o   = pstrb_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: directed and randomized bench for the two-requester
// APB master. A transaction-level model tracks who owns the bus and how many
// ACCESS cycles have elapsed, and predicts every registered output per cycle.
module tb_apb_master_arbiter;

  localparam int BUS_WIDTH  = 64;
  localparam int ADDR_WIDTH = 32;
  localparam int TIMEOUT    = 16;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [1:0]  req_i = '0;
  logic [1:0]  write_i = '0;
  logic [31:0] addr0_i = '0, addr1_i = '0;
  logic [63:0] wdata0_i = '0, wdata1_i = '0;
  logic [7:0]  strb0_i = '0, strb1_i = '0;
  logic [1:0]  gnt_o, done_o;
  logic        err_o;
  logic [63:0] rdata_o;
  logic        psel_o, penable_o, pwrite_o;
  logic [31:0] paddr_o;
  logic [63:0] pwdata_o;
  logic [7:0]  pstrb_o;
  logic        pready_i = 1'b0, pslverr_i = 1'b0, busy_i = 1'b0;
  logic [63:0] prdata_i = '0;

  int checks_total = 0;
  int checks_passed = 0;

  apb_master_arbiter #(
    .BUS_WIDTH(BUS_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .write_i(write_i),
    .addr0_i(addr0_i), .addr1_i(addr1_i), .wdata0_i(wdata0_i), .wdata1_i(wdata1_i),
    .strb0_i(strb0_i), .strb1_i(strb1_i), .gnt_o(gnt_o), .done_o(done_o),
    .err_o(err_o), .rdata_o(rdata_o), .psel_o(psel_o), .penable_o(penable_o),
    .pwrite_o(pwrite_o), .paddr_o(paddr_o), .pwdata_o(pwdata_o), .pstrb_o(pstrb_o),
    .pready_i(pready_i), .pslverr_i(pslverr_i), .prdata_i(prdata_i), .busy_i(busy_i)
  );

  // Free-running clock.
  always #5 clk_i = ~clk_i;

  // Reference model: a transfer is "active" from grant to the end of its done
  // cycle; m_cyc counts ACCESS cycles (0 means the setup cycle).
  logic        m_active, m_fin, m_owner, m_last, m_err;
  int          m_cyc;
  logic        m_pwrite;
  logic [31:0] m_paddr;
  logic [63:0] m_pwdata, m_rdata;
  logic [7:0]  m_pstrb;
  logic        w_pick;

  function automatic logic pick_winner(input logic [1:0] r, input logic last);
    if (r == 2'b01) return 1'b0;
    if (r == 2'b10) return 1'b1;
    return (last == 1'b1) ? 1'b0 : 1'b1;
  endfunction

  assign w_pick = pick_winner(req_i, m_last);

  // Advance the transaction model on each clock edge, resetting with the DUT.
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_active <= 1'b0; m_fin <= 1'b0; m_owner <= 1'b0; m_last <= 1'b1;
      m_err <= 1'b0; m_cyc <= 0; m_pwrite <= 1'b0; m_paddr <= '0;
      m_pwdata <= '0; m_rdata <= '0; m_pstrb <= '0;
    end else if (!m_active) begin
      if (req_i != 2'b00 && !busy_i) begin
        m_active <= 1'b1; m_fin <= 1'b0; m_cyc <= 0;
        m_owner <= w_pick; m_last <= w_pick;
        m_pwrite <= write_i[w_pick];
        m_paddr  <= w_pick ? addr1_i : addr0_i;
        m_pwdata <= w_pick ? wdata1_i : wdata0_i;
        m_pstrb  <= write_i[w_pick] ? (w_pick ? strb1_i : strb0_i) : 8'h00;
      end
    end else if (m_fin) begin
      m_active <= 1'b0; m_fin <= 1'b0;
    end else if (m_cyc == 0) begin
      m_cyc <= 1;
    end else if (pready_i) begin
      m_fin <= 1'b1; m_err <= pslverr_i; m_rdata <= m_pwrite ? 64'h0 : prdata_i;
    end else if (m_cyc == TIMEOUT) begin
      m_fin <= 1'b1; m_err <= 1'b1; m_rdata <= 64'h0;
    end else begin
      m_cyc <= m_cyc + 1;
    end
  end

  logic [1:0] exp_owner_hot;
  assign exp_owner_hot = m_owner ? 2'b10 : 2'b01;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks_total++;
    if (act !== exp)
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else
      checks_passed++;
  endtask

  // Compare every DUT output against the model once per cycle, away from the edge.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      check_output("model_ctrl", {psel_o, penable_o, gnt_o, done_o, err_o},
                   {m_active && !m_fin, m_active && !m_fin && (m_cyc != 0),
                    m_active ? exp_owner_hot : 2'b00, m_fin ? exp_owner_hot : 2'b00,
                    m_fin && m_err});
      check_output("model_pwrite", pwrite_o, m_pwrite);
      check_output("model_paddr", paddr_o, m_paddr);
      check_output("model_pwdata", pwdata_o, m_pwdata);
      check_output("model_pstrb", pstrb_o, m_pstrb);
      check_output("model_rdata", rdata_o, m_fin ? m_rdata : 64'h0);
    end
  end

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic apply_stimulus(input int n, input logic wr, input logic [31:0] a,
                                input logic [63:0] d, input logic [7:0] s);
    write_i[n] = wr;
    if (n == 0) begin addr0_i = a; wdata0_i = d; strb0_i = s; end
    else        begin addr1_i = a; wdata1_i = d; strb1_i = s; end
    req_i[n] = 1'b1;
  endtask

  // Hard stop in case something never terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no end of run, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [1:0] seen [4];
  int         seen_at [4];
  int         nseen;
  int         acc;
  bit         got;

  // Directed scenarios followed by randomized traffic.
  initial begin
    repeat (3) tick();
    rst_ni = 1'b1;
    tick();
    check_output("reset_ctrl", {psel_o, penable_o, pwrite_o, gnt_o, done_o, err_o}, 64'h0);
    check_output("reset_bus", {paddr_o, pstrb_o}, 64'h0);
    check_output("reset_rdata", rdata_o | pwdata_o, 64'h0);

    // Tie with both requests held: alternating grants, one done every 4 cycles.
    pready_i = 1'b1;
    apply_stimulus(0, 1'b1, 32'h10, 64'hA0, 8'h0F);
    apply_stimulus(1, 1'b1, 32'h20, 64'hB0, 8'hF0);
    nseen = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (done_o != 2'b00) begin
        if (nseen < 4) begin seen[nseen] = done_o; seen_at[nseen] = i; end
        nseen++;
      end
    end
    req_i = 2'b00;
    check_output("tie_done_count", nseen, 4);
    if (nseen >= 4) begin
      for (int k = 0; k < 4; k++)
        check_output("tie_order", seen[k], (k % 2 == 0) ? 2'b01 : 2'b10);
      check_output("tie_first_latency", seen_at[0], 3);
      for (int k = 1; k < 4; k++)
        check_output("tie_spacing", seen_at[k] - seen_at[k-1], 4);
    end
    tick();

    // Single write from requester 0 with zero wait states.
    apply_stimulus(0, 1'b1, 32'h1, 64'hDEADBEEF_01234567, 8'hFF);
    tick();
    check_output("wr_setup", {psel_o, penable_o, pwrite_o, gnt_o, done_o}, {1'b1, 1'b0, 1'b1, 2'b01, 2'b00});
    check_output("wr_addr", paddr_o, 32'h1);
    check_output("wr_data", pwdata_o, 64'hDEADBEEF_01234567);
    check_output("wr_strb", pstrb_o, 8'hFF);
    tick();
    check_output("wr_access", {psel_o, penable_o, gnt_o, done_o}, {1'b1, 1'b1, 2'b01, 2'b00});
    tick();
    check_output("wr_done", {psel_o, penable_o, gnt_o, done_o, err_o}, {1'b0, 1'b0, 2'b01, 2'b01, 1'b0});
    req_i[0] = 1'b0;
    tick();
    check_output("wr_after", {gnt_o, done_o}, 4'h0);
    check_output("wr_addr_hold", paddr_o, 32'h1);

    // Read from requester 1: strobes forced to zero, read data returned.
    prdata_i = 64'hCAFE;
    apply_stimulus(1, 1'b0, 32'h40, 64'h1111, 8'hFF);
    tick();
    check_output("rd_strb", pstrb_o, 8'h00);
    check_output("rd_gnt", gnt_o, 2'b10);
    tick();
    tick();
    check_output("rd_done", done_o, 2'b10);
    check_output("rd_data", rdata_o, 64'hCAFE);
    req_i[1] = 1'b0;
    tick();

    // Wait states: pready arrives on the third ACCESS cycle.
    pready_i = 1'b0;
    apply_stimulus(0, 1'b0, 32'h80, 64'h0, 8'h3C);
    tick(); tick(); tick(); tick();
    check_output("ws_still_access", {penable_o, done_o}, {1'b1, 2'b00});
    pready_i = 1'b1; prdata_i = 64'h1234_5678;
    tick();
    check_output("ws_done", {done_o, err_o}, {2'b01, 1'b0});
    check_output("ws_rdata", rdata_o, 64'h1234_5678);
    req_i[0] = 1'b0; pready_i = 1'b0;
    tick();

    // Timeout: pready never comes.
    prdata_i = 64'hFFFF;
    apply_stimulus(0, 1'b0, 32'h90, 64'h0, 8'hFF);
    acc = 0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      if (penable_o) acc++;
      if (done_o != 2'b00) got = 1'b1;
    end
    check_output("to_done_seen", got, 1'b1);
    check_output("to_access_cycles", acc, TIMEOUT);
    check_output("to_status", {psel_o, done_o, err_o}, {1'b0, 2'b01, 1'b1});
    check_output("to_rdata", rdata_o, 64'h0);
    req_i[0] = 1'b0;
    tick();

    // Slave error on a write from requester 1.
    pready_i = 1'b1; pslverr_i = 1'b1;
    apply_stimulus(1, 1'b1, 32'hA0, 64'h55, 8'h01);
    tick(); tick(); tick();
    check_output("slverr", {done_o, err_o}, {2'b10, 1'b1});
    req_i[1] = 1'b0; pslverr_i = 1'b0;
    tick();

    // Busy gating: no SETUP while busy, SETUP right after it falls.
    busy_i = 1'b1;
    apply_stimulus(0, 1'b1, 32'hB0, 64'h66, 8'h02);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_output("busy_hold", {psel_o, gnt_o}, 3'b000);
    end
    busy_i = 1'b0;
    tick();
    check_output("busy_release", {psel_o, gnt_o}, {1'b1, 2'b01});
    tick(); tick();
    req_i[0] = 1'b0;
    tick();

    // Reset in the middle of ACCESS, then a tie afterwards goes to requester 0.
    pready_i = 1'b0;
    apply_stimulus(0, 1'b1, 32'hC0, 64'h77, 8'hFF);
    tick(); tick();
    #2 rst_ni = 1'b0;
    #1 check_output("rst_async", {psel_o, penable_o, pwrite_o, gnt_o, done_o, err_o, pstrb_o, paddr_o}, 64'h0);
    check_output("rst_async_data", rdata_o | pwdata_o, 64'h0);
    apply_stimulus(1, 1'b0, 32'hD0, 64'h0, 8'hFF);
    tick(); tick();
    rst_ni = 1'b1;
    tick();
    check_output("rst_tie_gnt", {gnt_o, done_o}, {2'b01, 2'b00});
    pready_i = 1'b1;
    tick(); tick();
    req_i = 2'b00;
    tick();

    // Randomized traffic; requesters drop their request when they see done.
    for (int c = 0; c < 500; c++) begin
      busy_i    = ($urandom_range(0, 3) == 0);
      pready_i  = ($urandom_range(0, 2) != 0);
      pslverr_i = ($urandom_range(0, 7) == 0);
      prdata_i  = {$urandom, $urandom};
      for (int n = 0; n < 2; n++) begin
        if (req_i[n]) begin
          if (done_o[n]) req_i[n] = 1'b0;
        end else if ($urandom_range(0, 1) == 1) begin
          apply_stimulus(n, 1'($urandom_range(0, 1)), $urandom, {$urandom, $urandom},
                         8'($urandom_range(0, 255)));
        end
      end
      tick();
    end

    // Drain outstanding requests without raising new ones.
    busy_i = 1'b0; pready_i = 1'b1;
    for (int c = 0; c < 100 && req_i != 2'b00; c++) begin
      for (int n = 0; n < 2; n++)
        if (req_i[n] && done_o[n]) req_i[n] = 1'b0;
      tick();
    end
    check_output("drain_complete", req_i, 2'b00);
    tick(); tick();

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/apb_master_arbiter.md
# apb_master_arbiter

Two-requester APB master that shares the single APB port of the matmul accelerator's APB slave between requester 0 and requester 1 (e.g. host-side sequencer and DMA/loader). It performs round-robin arbitration and drives the APB SETUP/ACCESS protocol. It also waits on pready_i, returns read data, error and completion per requester, and aborts hung transfers with a timeout. It sits directly upstream of the APB slave; its APB outputs connect one-to-one to the slave's inputs.

## Interface
- BUS_WIDTH, 64, data bus width (bits).
- ADDR_WIDTH, 32, address width (bits).
- TIMEOUT, 16, maximum ACCESS-phase length in cycles; must be >= 1.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_i  in  2  per-requester request; held high until done_o[n].
- write_i  in  2  per-requester direction: 1 = write, 0 = read.
- addr0_i, addr1_i  in  ADDR_WIDTH  requester addresses.
- wdata0_i, wdata1_i  in  BUS_WIDTH  requester write data.
- strb0_i, strb1_i  in  BUS_WIDTH/8  requester byte strobes.
- gnt_o  out  2  one-hot grant; high from SETUP through DONE.
- done_o  out  2  one-cycle completion pulse to the granted requester.
- err_o  out  1  completion status; valid while done_o != 0.
- rdata_o  out  BUS_WIDTH  read data; valid while done_o != 0 on a read.
- psel_o, penable_o, pwrite_o  out  1  APB control.
- paddr_o  out  ADDR_WIDTH  APB address.
- pwdata_o  out  BUS_WIDTH  APB write data.
- pstrb_o  out  BUS_WIDTH/8  APB strobes.
- pready_i, pslverr_i  in  1  APB slave response.
- prdata_i  in  BUS_WIDTH  APB read data.
- busy_i  in  1  slave busy; no new SETUP while high.

## Operation
- FSM states: IDLE, SETUP, ACCESS, DONE. All outputs registered.
- IDLE to SETUP: taken when req_i != 0 and busy_i == 0.
  - Winner with one requester: the active one.
  - Winner with both active: the one not equal to last_gnt. last_gnt updates on every grant.
  - On the transition, latch the winner's write, addr, wdata and strb into the APB output registers. pstrb_o is forced to 0 for reads.
  - Set gnt_o, psel_o=1, penable_o=0.
- SETUP to ACCESS: unconditional after one cycle; penable_o=1. Timeout counter cleared.
- ACCESS, with pready_i=1:
  - Go to DONE; psel_o and penable_o drop to 0.
  - err_o=pslverr_i; rdata_o=prdata_i on reads, else 0.
  - done_o[g]=1.
- ACCESS, timeout: pready_i=0 for TIMEOUT consecutive ACCESS cycles.
  - Go to DONE with err_o=1, rdata_o=0, done_o[g]=1; psel_o and penable_o drop to 0.
  - pready_i in the TIMEOUT-th ACCESS cycle is a normal completion.
- DONE to IDLE: after one cycle. done_o, gnt_o, err_o and rdata_o return to 0.
  - No grant is made in DONE.
  - A requester must drop req_i on seeing done_o. A req_i still high in the following IDLE is a new transaction.
- paddr_o, pwdata_o and pwrite_o hold their values outside SETUP/ACCESS. pstrb_o holds too, but is forced to 0 for reads.
- Timeout counter width: $clog2(TIMEOUT+1). It saturates, so no wrap.
- Reset values:
  - Outputs: psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o, gnt_o, done_o, err_o and rdata_o are all 0.
  - Internal: state=IDLE, last_gnt=1, so requester 0 wins the first tie.
- Reset mid-transfer: all outputs go to reset values immediately and no done_o is issued. Requesters re-request after reset.
- req_i changes while not granted are ignored until IDLE.
- busy_i is sampled only in IDLE.

## Timing
- req_i sampled high in IDLE at edge k:
  - SETUP during cycle k+1.
  - ACCESS from k+2.
  - With zero-wait pready_i: DONE (done_o high) in cycle k+3, IDLE in k+4.
- Minimum request-to-done latency: 3 cycles.
- Each pready_i wait cycle adds 1 cycle.
- Back-to-back throughput: one transfer per 4 cycles.
- APB rule: psel_o is high through SETUP and ACCESS; penable_o is high only in ACCESS. Address, data, write and strobe are stable from SETUP to end of ACCESS.

## Test plan
- Single write:
  - Stimulus: req_i=01, write_i=01, addr0=0x1, wdata0=0xDEADBEEF_01234567, strb0=0xFF; slave pready_i=1 in ACCESS.
  - Required: psel_o at k+1, penable_o at k+2, done_o=01 with err_o=0 at k+3, gnt_o=01 over k+1..k+3.
- Read:
  - Stimulus: requester 1 read with strb1=0xFF; prdata_i=0xCAFE.
  - Required: pstrb_o=0, rdata_o=0xCAFE, done_o=10.
- Tie and round-robin:
  - Stimulus: req_i=11 held, each requester re-requesting immediately.
  - Required: grant order 0,1,0,1 after reset; done pulses spaced 4 cycles.
- Wait states and timeout:
  - Stimulus: pready_i high on ACCESS cycle 3 (TIMEOUT=16).
  - Required: done_o after 3 ACCESS cycles with err_o=0.
  - Stimulus: pready_i never high.
  - Required: done_o with err_o=1, rdata_o=0 after exactly 16 ACCESS cycles; psel_o=0 in DONE.
- Slave error and busy gating:
  - Stimulus: pslverr_i=1 with pready_i.
  - Required: err_o=1.
  - Stimulus: busy_i=1 with req_i=01.
  - Required: stays IDLE, psel_o=0 until busy_i falls; SETUP the next cycle after it falls.
- Reset mid-ACCESS:
  - Stimulus: assert rst_ni low during ACCESS.
  - Required: all outputs 0 asynchronously, no done_o; after release, a tie is granted to requester 0.
